// File: rtl/exec_pkg.sv
// Shared opcode constants and function-code enums for the execute stage.
package exec_pkg;

  localparam logic [6:0] OP_R   = 7'b0000001;
  localparam logic [6:0] OP_I   = 7'b0000011;
  localparam logic [6:0] OP_BR  = 7'b0000111;
  localparam logic [6:0] OP_JMP = 7'b0001111;

  // ALU codes are {funct7[5], funct3}
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_func_e;

  typedef enum logic [3:0] {
    BR_EQ  = 4'b0000,
    BR_NE  = 4'b0001,
    BR_LT  = 4'b0100,
    BR_GE  = 4'b0101,
    BR_LTU = 4'b0110,
    BR_GEU = 4'b0111
  } br_func_e;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU shared by R-type and I-type instructions.
module exec_alu
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      func,
  output logic [XLEN-1:0] y,
  output logic            illegal
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (func)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU / branch compare / jump, all results registered once.
module execute_stage
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [6:0]      opcode,
  input  logic [3:0]      func,
  output logic [XLEN-1:0] sonuc,
  output logic            pc_update,
  output logic            we,
  output logic            hata
);

  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_y;
  logic            alu_illegal;
  logic            br_taken;
  logic            br_legal;

  logic [XLEN-1:0] sonuc_reg, sonuc_next;
  logic            pc_update_reg, pc_update_next;
  logic            we_reg, we_next;
  logic            hata_reg, hata_next;

  assign alu_b = (opcode == OP_I) ? imm : rs2_data;

  exec_alu #(.XLEN(XLEN)) u_alu (
    .a       (rs1_data),
    .b       (alu_b),
    .func    (func),
    .y       (alu_y),
    .illegal (alu_illegal)
  );

  always_comb begin
    br_taken = 1'b0;
    br_legal = 1'b1;
    case (func)
      BR_EQ:   br_taken = (rs1_data == rs2_data);
      BR_NE:   br_taken = (rs1_data != rs2_data);
      BR_LT:   br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      BR_GE:   br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      BR_LTU:  br_taken = (rs1_data <  rs2_data);
      BR_GEU:  br_taken = (rs1_data >= rs2_data);
      default: br_legal = 1'b0;
    endcase
  end

  // Illegal instructions leave every other output at zero.
  always_comb begin
    sonuc_next     = '0;
    pc_update_next = 1'b0;
    we_next        = 1'b0;
    hata_next      = 1'b0;
    case (opcode)
      OP_R: begin
        if (alu_illegal) begin
          hata_next = 1'b1;
        end else begin
          sonuc_next = alu_y;
          we_next    = 1'b1;
        end
      end
      OP_I: begin
        if (alu_illegal || func == ALU_SUB) begin
          hata_next = 1'b1;
        end else begin
          sonuc_next = alu_y;
          we_next    = 1'b1;
        end
      end
      OP_BR: begin
        if (!br_legal) begin
          hata_next = 1'b1;
        end else begin
          sonuc_next     = imm;
          pc_update_next = br_taken;
        end
      end
      OP_JMP: begin
        sonuc_next     = imm;
        pc_update_next = 1'b1;
      end
      default: hata_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sonuc_reg     <= '0;
      pc_update_reg <= 1'b0;
      we_reg        <= 1'b0;
      hata_reg      <= 1'b0;
    end else begin
      sonuc_reg     <= sonuc_next;
      pc_update_reg <= pc_update_next;
      we_reg        <= we_next;
      hata_reg      <= hata_next;
    end
  end

  assign sonuc     = sonuc_reg;
  assign pc_update = pc_update_reg;
  assign we        = we_reg;
  assign hata      = hata_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus random bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] imm = '0;
  logic [6:0]  opcode = '0;
  logic [3:0]  func = '0;
  logic [31:0] sonuc;
  logic        pc_update;
  logic        we;
  logic        hata;

  int checks = 0;
  int errors = 0;

  execute_stage #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .imm       (imm),
    .opcode    (opcode),
    .func      (func),
    .sonuc     (sonuc),
    .pc_update (pc_update),
    .we        (we),
    .hata      (hata)
  );

  always #5 clk = ~clk;

  // Reference model: instruction semantics written directly as arithmetic.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] r2,
                                    input logic [31:0] im, input logic [6:0] op,
                                    input logic [3:0] f, output logic [31:0] res,
                                    output logic pc, output logic wr, output logic err);
    logic [31:0] b;
    logic        ok;
    logic [31:0] y;
    res = 0; pc = 0; wr = 0; err = 0;
    b  = (op == 7'b0000011) ? im : r2;
    ok = 1; y = 0;
    case (f)
      4'd0:  y = a + b;
      4'd8:  y = a - b;
      4'd1:  y = a << (b % 32);
      4'd5:  y = a >> (b % 32);
      4'd13: y = $unsigned($signed(a) >>> (b % 32));
      4'd2:  y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  y = (a < b) ? 32'd1 : 32'd0;
      4'd4:  y = a ^ b;
      4'd6:  y = a | b;
      4'd7:  y = a & b;
      default: ok = 0;
    endcase
    if (op == 7'b0000001 || op == 7'b0000011) begin
      if (!ok || (op == 7'b0000011 && f == 4'd8)) err = 1;
      else begin res = y; wr = 1; end
    end else if (op == 7'b0000111) begin
      ok = 1;
      case (f)
        4'd0: pc = (a == r2);
        4'd1: pc = (a != r2);
        4'd4: pc = ($signed(a) < $signed(r2));
        4'd5: pc = !($signed(a) < $signed(r2));
        4'd6: pc = (a < r2);
        4'd7: pc = !(a < r2);
        default: ok = 0;
      endcase
      if (!ok) begin err = 1; pc = 0; end
      else res = im;
    end else if (op == 7'b0001111) begin
      res = im; pc = 1;
    end else begin
      err = 1;
    end
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk32({tag, "_sonuc"}, sonuc, 32'h0);
    chk1({tag, "_pc"}, pc_update, 1'b0);
    chk1({tag, "_we"}, we, 1'b0);
    chk1({tag, "_hata"}, hata, 1'b0);
  endtask

  // Apply one instruction, clock it in, then compare against the model.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input logic [6:0] op, input logic [3:0] f);
    logic [31:0] e_res;
    logic        e_pc, e_we, e_err;
    rs1_data = a; rs2_data = b; imm = im; opcode = op; func = f;
    ref_model(a, b, im, op, f, e_res, e_pc, e_we, e_err);
    @(posedge clk);
    #1;
    chk32({tag, "_sonuc"}, sonuc, e_res);
    chk1({tag, "_pc"}, pc_update, e_pc);
    chk1({tag, "_we"}, we, e_we);
    chk1({tag, "_hata"}, hata, e_err);
    $display("txn %s op=%b func=%b rs1=%h rs2=%h imm=%h -> sonuc=%h pc=%b we=%b hata=%b",
             tag, op, f, a, b, im, sonuc, pc_update, we, hata);
  endtask

  localparam logic [6:0] R = 7'b0000001, I = 7'b0000011, B = 7'b0000111, J = 7'b0001111;

  initial begin
    logic [6:0] rop;
    // 1: reset with arbitrary inputs holds everything at zero
    rs1_data = 32'hDEADBEEF; rs2_data = 32'h12345678; imm = 32'hCAFEF00D;
    opcode = R; func = 4'b0000;
    #2;
    chk_zero("reset_async");
    @(posedge clk); #1;
    chk_zero("reset_held");
    rst_n = 1'b1;
    step("r_add", 32'd16, 32'd8, 32'd0, R, 4'b0000);
    chk32("r_add_const", sonuc, 32'd24);

    // 2: R-type sweep
    step("r_sra",  32'd16, 32'd8, 32'd0, R, 4'b1101);
    step("r_and",  32'd16, 32'd8, 32'd0, R, 4'b0111);
    step("r_or",   32'd16, 32'd8, 32'd0, R, 4'b0110);
    step("r_sll",  32'd16, 32'd8, 32'd0, R, 4'b0001);
    chk32("r_sll_const", sonuc, 32'd4096);
    step("r_srl",  32'd16, 32'd8, 32'd0, R, 4'b0101);
    step("r_sub",  32'd8, 32'd16, 32'd0, R, 4'b1000);
    chk32("r_sub_const", sonuc, 32'hFFFFFFF8);
    step("r_slt",  32'hFFFFFFFF, 32'd1, 32'd0, R, 4'b0010);
    chk32("r_slt_const", sonuc, 32'd1);
    step("r_sltu", 32'hFFFFFFFF, 32'd1, 32'd0, R, 4'b0011);
    step("r_sra_neg", 32'h80000000, 32'd4, 32'd0, R, 4'b1101);
    step("r_bad",  32'd16, 32'd8, 32'd0, R, 4'b1111);

    // 3: I-type
    step("i_add",  32'd16, 32'd99, 32'd128, I, 4'b0000);
    chk32("i_add_const", sonuc, 32'd144);
    step("i_or",   32'd16, 32'd99, 32'd128, I, 4'b0110);
    step("i_and",  32'd16, 32'd99, 32'd128, I, 4'b0111);
    step("i_sll0", 32'd16, 32'd99, 32'd128, I, 4'b0001);
    step("i_sub",  32'd16, 32'd99, 32'd128, I, 4'b1000);
    chk1("i_sub_hata_const", hata, 1'b1);

    // 4: branches
    step("b_eq",   32'd16, 32'd8, 32'd128, B, 4'b0000);
    step("b_ne",   32'd16, 32'd8, 32'd128, B, 4'b0001);
    step("b_ge",   32'd16, 32'd8, 32'd128, B, 4'b0101);
    step("b_ltu",  32'd16, 32'd8, 32'd128, B, 4'b0110);
    step("b_geu",  32'd16, 32'd8, 32'd128, B, 4'b0111);
    step("b_lt_s", 32'hFFFFFFF0, 32'd8, 32'd128, B, 4'b0100);
    step("b_bad",  32'd16, 32'd8, 32'd128, B, 4'b1101);

    // 5: jump and undefined opcode
    step("j_0",    32'd16, 32'd8, 32'd128, J, 4'b1111);
    step("j_1",    32'd16, 32'd8, 32'd128, J, 4'b1000);
    step("op_bad", 32'd16, 32'd8, 32'd128, 7'b0000000, 4'b0000);
    step("clear",  32'd16, 32'd8, 32'd0, R, 4'b0000);

    // 6: asynchronous reset in the middle of a held ADD
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(posedge clk); #1;
    chk_zero("mid_reset_held");
    #2;
    rst_n = 1'b1;
    #1;
    chk_zero("released_before_edge");
    step("resume", 32'd16, 32'd8, 32'd0, R, 4'b0000);

    // Random instructions
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: rop = R;
        1: rop = I;
        2: rop = B;
        3: rop = J;
        default: rop = 7'($urandom);
      endcase
      step("rand", ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
           $urandom, rop, 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
